// File: rtl/vram_arbiter.sv
// Single-port text RAM arbiter: GPU fetch > CPU port > fill/scroll block engine.
// Optional build macro VRAM_ARBITER_SCROLL_DOWN_EN adds op 2 (scroll down).
module vram_arbiter #(
  parameter int COLS = 80,
  parameter int ROWS = 25
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        gpu_req,
  input  logic [11:0] gpu_address,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [11:0] cpu_address,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ready,
  input  logic        cmd_start,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_fill,
  output logic        busy,
  output logic        done,
  output logic [11:0] ram_address,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  input  logic [7:0]  ram_q
);

  localparam logic [11:0] ROW_BYTES  = 12'(2 * COLS);
  localparam logic [11:0] SCREEN_END = 12'(2 * COLS * ROWS);
  localparam logic [11:0] SCROLL_END = 12'(2 * COLS * (ROWS - 1));

  typedef enum logic {C_IDLE, C_ACK} cpu_state_t;
  typedef enum logic [2:0] {E_IDLE, E_READ, E_WRITE, E_FILL, E_DONE} eng_state_t;

  cpu_state_t  cpu_state, cpu_state_next;
  eng_state_t  eng_state, eng_state_next;
  logic        cpu_write;
  logic [11:0] index, index_next;
  logic [15:0] pattern, pattern_next;
  logic        down, down_next;
  logic        capture_pending;
  logic [7:0]  hold;
  logic        cpu_grant, eng_active, eng_grant;
  logic [11:0] read_address;
  logic [7:0]  write_byte, fill_byte;

  always_ff @(posedge clock) begin
    if (reset) begin
      cpu_state       <= C_IDLE;
      eng_state       <= E_IDLE;
      cpu_write       <= 1'b0;
      index           <= '0;
      pattern         <= '0;
      down            <= 1'b0;
      capture_pending <= 1'b0;
      hold            <= '0;
    end else begin
      cpu_state       <= cpu_state_next;
      eng_state       <= eng_state_next;
      index           <= index_next;
      pattern         <= pattern_next;
      down            <= down_next;
      if (cpu_grant)
        cpu_write <= cpu_we;
      // ram_q is valid the cycle after a granted read, whoever owns the RAM then
      capture_pending <= (eng_state == E_READ) && eng_grant;
      if (capture_pending)
        hold <= ram_q;
    end
  end

  always_comb begin
    cpu_grant    = (cpu_state == C_IDLE) && cpu_req && !gpu_req;
    eng_active   = (eng_state == E_READ) || (eng_state == E_WRITE) || (eng_state == E_FILL);
    eng_grant    = eng_active && !gpu_req && !cpu_grant;
    read_address = down ? (index - ROW_BYTES) : (index + ROW_BYTES);
    write_byte   = capture_pending ? ram_q : hold;
    fill_byte    = index[0] ? pattern[7:0] : pattern[15:8];
  end

  always_comb begin
    cpu_state_next = cpu_state;
    case (cpu_state)
      C_IDLE:  if (cpu_grant) cpu_state_next = C_ACK;
      C_ACK:   cpu_state_next = C_IDLE;
      default: cpu_state_next = C_IDLE;
    endcase
  end

  always_comb begin
    eng_state_next = eng_state;
    index_next     = index;
    pattern_next   = pattern;
    down_next      = down;
    case (eng_state)
      E_IDLE: begin
        if (cmd_start) begin
          pattern_next = cmd_fill;
          index_next   = '0;
          down_next    = 1'b0;
          case (cmd_op)
            2'd0: eng_state_next = E_FILL;
            2'd1: eng_state_next = E_READ;
`ifdef VRAM_ARBITER_SCROLL_DOWN_EN
            2'd2: begin
              eng_state_next = E_READ;
              index_next     = SCREEN_END - 12'd1;
              down_next      = 1'b1;
            end
`endif
            default: eng_state_next = E_DONE;
          endcase
        end
      end
      E_READ: begin
        if (eng_grant)
          eng_state_next = E_WRITE;
      end
      E_WRITE: begin
        if (eng_grant) begin
          if (down) begin
            index_next     = index - 12'd1;
            eng_state_next = (index == ROW_BYTES) ? E_FILL : E_READ;
          end else begin
            index_next     = index + 12'd1;
            eng_state_next = ((index + 12'd1) == SCROLL_END) ? E_FILL : E_READ;
          end
        end
      end
      E_FILL: begin
        if (eng_grant) begin
          if (down) begin
            index_next = index - 12'd1;
            if (index == 12'd0)
              eng_state_next = E_DONE;
          end else begin
            index_next = index + 12'd1;
            if ((index + 12'd1) == SCREEN_END)
              eng_state_next = E_DONE;
          end
        end
      end
      E_DONE:  eng_state_next = E_IDLE;
      default: eng_state_next = E_IDLE;
    endcase
  end

  // RAM mux: GPU wins outright, then a fresh CPU grant, then the engine
  always_comb begin
    ram_address = '0;
    ram_wdata   = '0;
    ram_we      = 1'b0;
    if (!reset) begin
      if (gpu_req) begin
        ram_address = gpu_address;
      end else if (cpu_grant) begin
        ram_address = cpu_address;
        ram_wdata   = cpu_wdata;
        ram_we      = cpu_we;
      end else if (eng_grant) begin
        case (eng_state)
          E_READ: ram_address = read_address;
          E_WRITE: begin
            ram_address = index;
            ram_wdata   = write_byte;
            ram_we      = 1'b1;
          end
          E_FILL: begin
            ram_address = index;
            ram_wdata   = fill_byte;
            ram_we      = 1'b1;
          end
          default: ram_address = '0;
        endcase
      end
    end
  end

  assign cpu_ready = (cpu_state == C_ACK);
  assign cpu_rdata = ((cpu_state == C_ACK) && !cpu_write) ? ram_q : 8'h00;
  assign busy      = eng_active;
  assign done      = (eng_state == E_DONE);

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: behavioural RAM, a work-counting model checked every cycle,
// and directed fill/scroll/CPU/GPU/reset scenarios with hand-computed results.
`timescale 1ns/1ps
module tb_vram_arbiter;

  localparam int SCREEN     = 4000;
  localparam int SCROLL_END = 3840;
  localparam int ROWB       = 160;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        gpu_req = 1'b0;
  logic [11:0] gpu_address = '0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [11:0] cpu_address = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata;
  logic        cpu_ready;
  logic        cmd_start = 1'b0;
  logic [1:0]  cmd_op = '0;
  logic [15:0] cmd_fill = '0;
  logic        busy, done;
  logic [11:0] ram_address;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_q;

  int n_vec = 0;
  int n_miss = 0;
  bit chk_en = 0;

  always #5 clock = ~clock;

  vram_arbiter dut (
    .clock(clock), .reset(reset),
    .gpu_req(gpu_req), .gpu_address(gpu_address),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_address(cpu_address),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .cmd_start(cmd_start), .cmd_op(cmd_op), .cmd_fill(cmd_fill),
    .busy(busy), .done(done),
    .ram_address(ram_address), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_q(ram_q)
  );

  function automatic logic [7:0] pre_val(input int kind, input int i);
    logic [11:0] a;
    a = 12'(i);
    return (kind == 1) ? (a[7:0] ^ 8'h33) : a[7:0];
  endfunction

  // Registered single-port RAM, with a whole-array preload hook
  logic [7:0] mem [4096];
  int preload_kind = 0;
  always @(posedge clock) begin
    if (preload_kind != 0) begin
      for (int i = 0; i < 4096; i++) mem[i] <= pre_val(preload_kind, i);
    end else if (ram_we) begin
      mem[ram_address] <= ram_wdata;
    end
    ram_q <= mem[ram_address];
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Model: an op is a number of RAM steps; a step happens on each busy cycle
  // that neither the GPU nor a new CPU grant takes.
  bit m_busy = 0, m_done = 0, m_ack = 0;
  int m_left = 0;
  always @(posedge clock) begin : model
    bit win, nb, nd;
    int nl;
    win = cpu_req && !gpu_req && !m_ack;
    nb = m_busy;
    nd = 1'b0;
    nl = m_left;
    if (m_busy) begin
      if (!gpu_req && !win) nl = nl - 1;
      if (nl == 0) begin
        nb = 1'b0;
        nd = 1'b1;
      end
    end else if (!m_done && cmd_start) begin
      case (cmd_op)
        2'd0: begin nl = SCREEN; nb = 1'b1; end
        2'd1: begin nl = 2 * SCROLL_END + (SCREEN - SCROLL_END); nb = 1'b1; end
`ifdef VRAM_ARBITER_SCROLL_DOWN_EN
        2'd2: begin nl = 2 * SCROLL_END + (SCREEN - SCROLL_END); nb = 1'b1; end
`endif
        default: nd = 1'b1;
      endcase
    end
    if (reset) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_ack <= 1'b0; m_left <= 0;
    end else begin
      m_busy <= nb; m_done <= nd; m_ack <= win; m_left <= nl;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check_output("busy_done_ready", {29'b0, busy, done, cpu_ready}, {29'b0, m_busy, m_done, m_ack});
      if (gpu_req)
        check_output("gpu_slot", {19'b0, ram_we, ram_address}, {20'b0, gpu_address});
    end
  end

  task automatic check_image(input int kind, input int op, input logic [15:0] pat,
                             input bit ovr, input int ovr_addr, input logic [7:0] ovr_val);
    int bad, first;
    logic [7:0] e, fe, fa;
    bad = 0; first = -1; fe = '0; fa = '0;
    for (int i = 0; i < 4096; i++) begin
      e = pre_val(kind, i);
      if (op == 0 && i < SCREEN) e = (i % 2 == 1) ? pat[7:0] : pat[15:8];
      if (op == 1) begin
        if (i < SCROLL_END) e = pre_val(kind, i + ROWB);
        else if (i < SCREEN) e = (i % 2 == 1) ? pat[7:0] : pat[15:8];
      end
      if (op == 2) begin
        if (i < ROWB) e = (i % 2 == 1) ? pat[7:0] : pat[15:8];
        else if (i < SCREEN) e = pre_val(kind, i - ROWB);
      end
      if (ovr && i == ovr_addr) e = ovr_val;
      if (mem[i] !== e) begin
        if (first < 0) begin first = i; fe = e; fa = mem[i]; end
        bad++;
      end
    end
    n_vec++;
    if (bad != 0) begin
      n_miss++;
      $display("[TB] FAIL image: %0d bad bytes, first addr %0d got %h want %h", bad, first, fa, fe);
    end
  endtask

  int r_done, r_ready;
  logic [7:0] r_rdata;
  logic r_busy1, r_busy_rst;

  task automatic preload(input int kind);
    @(posedge clock); #1;
    preload_kind = kind;
    @(posedge clock); #1;
    preload_kind = 0;
  endtask

  task automatic apply_stimulus(input bit do_start, input logic [1:0] op, input logic [15:0] pat,
                                input int gpu_hold, input int gpu_period, input int restart_at,
                                input int cpu_at, input logic cwe, input logic [11:0] caddr,
                                input logic [7:0] cwd, input int reset_at, input int budget);
    @(posedge clock); #1;
    cmd_start = do_start; cmd_op = op; cmd_fill = pat;
    r_done = -1; r_ready = -1; r_rdata = '0; r_busy1 = 1'bx; r_busy_rst = 1'bx;
    for (int c = 0; c < budget; c++) begin
      if (c > 0) begin
        @(posedge clock); #1;
        cmd_start = (c == restart_at);
        cmd_op    = (c == restart_at) ? 2'd1 : 2'd3;
        cmd_fill  = 16'hFFFF;
        if (r_ready >= 0) cpu_req = 1'b0;
      end
      gpu_req = (c < gpu_hold) || (gpu_period > 0 && c > 0 && c % gpu_period == 0);
      gpu_address = 12'($urandom_range(0, 4095));
      if (c == cpu_at) begin
        cpu_req = 1'b1; cpu_we = cwe; cpu_address = caddr; cpu_wdata = cwd;
      end
      reset = (reset_at >= 0 && c == reset_at);
      @(negedge clock);
      if (c == 1) r_busy1 = busy;
      if (reset_at >= 0 && c == reset_at + 1) r_busy_rst = busy;
      if (cpu_ready && r_ready < 0) begin r_ready = c; r_rdata = cpu_rdata; end
      if (do_start && done && r_done < 0) begin r_done = c; break; end
      if (!do_start && r_ready >= 0) break;
      if (reset_at >= 0 && c >= reset_at + 200) break;
    end
    @(posedge clock); #1;
    cmd_start = 1'b0; gpu_req = 1'b0; cpu_req = 1'b0; reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    @(posedge clock); #1;
    chk_en = 1;
    @(negedge clock);
    check_output("reset_outputs", {cpu_ready, cpu_rdata, busy, done, ram_we, ram_address, ram_wdata},
                 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;

    $display("[TB] CPU read blocked by GPU");
    preload(1);
    apply_stimulus(0, 2'd0, 16'h0, 3, 0, -1, 0, 1'b0, 12'd5, 8'h00, -1, 50);
    check_output("cpu_ready_cycle", r_ready, 4);
    check_output("cpu_rdata", {24'b0, r_rdata}, 32'h36);

    $display("[TB] fill, no contention");
    apply_stimulus(1, 2'd0, 16'h4107, 0, 0, -1, -1, 1'b0, 12'd0, 8'h00, -1, 6000);
    check_output("fill_done_cycle", r_done, 4001);
    check_output("fill_ram0", {24'b0, mem[0]}, 32'h41);
    check_output("fill_ram1", {24'b0, mem[1]}, 32'h07);
    check_output("fill_ram3999", {24'b0, mem[3999]}, 32'h07);
    check_output("fill_ram4000", {24'b0, mem[4000]}, 32'h93);
    check_image(1, 0, 16'h4107, 0, 0, 8'h00);

    $display("[TB] fill with GPU every 4th cycle, ignored restart");
    apply_stimulus(1, 2'd0, 16'h5C3E, 0, 4, 50, -1, 1'b0, 12'd0, 8'h00, -1, 7000);
    check_output("gpu_fill_done_cycle", r_done, 5334);
    check_image(1, 0, 16'h5C3E, 0, 0, 8'h00);

    $display("[TB] scroll up, no contention");
    preload(2);
    apply_stimulus(1, 2'd1, 16'h2017, 0, 0, -1, -1, 1'b0, 12'd0, 8'h00, -1, 9000);
    check_output("scroll_done_cycle", r_done, 7841);
    check_output("scroll_ram0", {24'b0, mem[0]}, 32'hA0);
    check_output("scroll_ram3838", {24'b0, mem[3838]}, 32'h9E);
    check_output("scroll_ram3840", {24'b0, mem[3840]}, 32'h20);
    check_output("scroll_ram3841", {24'b0, mem[3841]}, 32'h17);
    check_output("scroll_ram3999", {24'b0, mem[3999]}, 32'h17);
    check_image(2, 1, 16'h2017, 0, 0, 8'h00);

    $display("[TB] scroll up with CPU write");
    preload(2);
    apply_stimulus(1, 2'd1, 16'h2017, 0, 0, -1, 100, 1'b1, 12'hFA0, 8'h5A, -1, 9000);
    check_output("cpu_scroll_ready_cycle", r_ready, 101);
    check_output("cpu_scroll_done_cycle", r_done, 7842);
    check_output("cpu_write_ram", {24'b0, mem[12'hFA0]}, 32'h5A);
    check_image(2, 1, 16'h2017, 1, 12'hFA0, 8'h5A);

    $display("[TB] reset mid-scroll");
    preload(2);
    apply_stimulus(1, 2'd1, 16'h2017, 0, 0, -1, -1, 1'b0, 12'd0, 8'h00, 1000, 1300);
    check_output("reset_no_done", r_done, 32'hFFFFFFFF);
    check_output("reset_busy_after", {31'b0, r_busy_rst}, 0);

    $display("[TB] reserved op 3");
    apply_stimulus(1, 2'd3, 16'h0, 0, 0, -1, -1, 1'b0, 12'd0, 8'h00, -1, 20);
    check_output("op3_done_cycle", r_done, 1);
    check_output("op3_busy", {31'b0, r_busy1}, 0);

    $display("[TB] fill after reset");
    apply_stimulus(1, 2'd0, 16'h3A5B, 0, 0, -1, -1, 1'b0, 12'd0, 8'h00, -1, 6000);
    check_output("refill_busy", {31'b0, r_busy1}, 1);
    check_output("refill_done_cycle", r_done, 4001);
    check_image(2, 0, 16'h3A5B, 0, 0, 8'h00);

    $display("[TB] op 2");
    preload(2);
    apply_stimulus(1, 2'd2, 16'h2017, 0, 0, -1, -1, 1'b0, 12'd0, 8'h00, -1, 9000);
`ifdef VRAM_ARBITER_SCROLL_DOWN_EN
    check_output("op2_done_cycle", r_done, 7841);
    check_image(2, 2, 16'h2017, 0, 0, 8'h00);
`else
    check_output("op2_done_cycle", r_done, 1);
    check_output("op2_busy", {31'b0, r_busy1}, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
